// File: rtl/apu_sdm_mc_pkg.sv
// Shared constants and helpers for the multi-channel sigma-delta PWM modulator.
// Optional dither is enabled by defining APU_SDM_MC_DITHER_EN.
package apu_sdm_mc_pkg;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam int          MAX_W     = 64;

  // Two's complement to offset binary is an MSB flip; unsigned input passes through.
  function automatic logic [MAX_W-1:0] to_offset(input logic [MAX_W-1:0] d,
                                                 input int w,
                                                 input bit signed_in);
    logic [MAX_W-1:0] mask;
    mask = '0;
    if (signed_in) mask[w-1] = 1'b1;
    return d ^ mask;
  endfunction

endpackage

// File: rtl/apu_sdm_mc_if.sv
// Sample-frame stream between the APU mixer and the sigma-delta modulator.
interface apu_sdm_mc_if #(
  parameter int N_CH     = 2,
  parameter int W_SAMPLE = 16
);
  logic [N_CH*W_SAMPLE-1:0] s_data;
  logic                     s_valid;
  logic                     s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/apu_sdm_mc_ch.sv
// One modulator channel: held sample, residual-carrying accumulator and PWM comparator.
module apu_sdm_mc_ch
  import apu_sdm_mc_pkg::*;
#(
  parameter int W_SAMPLE  = 16,
  parameter int W_PWM     = 4,
  parameter int SIGNED_IN = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        wrap,
  input  logic                        use_buf,
  input  logic [W_SAMPLE-1:0]         buf_sample,
  input  logic [W_SAMPLE-W_PWM-1:0]   dither,
  input  logic [W_PWM-1:0]            pwm_ctr,
  output logic                        q
);
  localparam int R = W_SAMPLE - W_PWM;

  logic [W_SAMPLE-1:0] hold_reg;
  logic [W_SAMPLE:0]   accum_reg;
  logic [W_SAMPLE:0]   accum_next;
  logic [W_SAMPLE-1:0] raw;
  logic [W_SAMPLE-1:0] sample;
  logic [W_PWM:0]      level;

  assign raw    = use_buf ? buf_sample : hold_reg;
  assign sample = W_SAMPLE'(to_offset(MAX_W'(raw), W_SAMPLE, SIGNED_IN != 0));

  // Only the residual below the PWM step is carried into the next frame.
  assign accum_next = (W_SAMPLE+1)'(accum_reg[R-1:0])
                    + (W_SAMPLE+1)'(dither)
                    + (W_SAMPLE+1)'(sample);
  assign level = accum_reg[W_SAMPLE:R];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg  <= '0;
      accum_reg <= '0;
      q         <= 1'b0;
    end else begin
      if (wrap && use_buf) hold_reg <= buf_sample;
      if (!en) begin
        accum_reg <= '0;
        q         <= 1'b0;
      end else begin
        if (wrap) accum_reg <= accum_next;
        q <= (level > {1'b0, pwm_ctr});
      end
    end
  end

endmodule

// File: rtl/apu_sdm_mc.sv
// Multi-channel sigma-delta PWM audio modulator with a one-deep frame buffer.
// Define APU_SDM_MC_DITHER_EN to add per-channel LFSR dither.
module apu_sdm_mc
  import apu_sdm_mc_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int W_SAMPLE  = 16,
  parameter int W_PWM     = 4,
  parameter int SIGNED_IN = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  apu_sdm_mc_if.slave     stream,
  output logic            frame,
  output logic [N_CH-1:0] q
);
  localparam int R = W_SAMPLE - W_PWM;

  logic [W_PWM-1:0]         ctr_reg;
  logic                     full_reg;
  logic [N_CH*W_SAMPLE-1:0] pend_reg;
  logic                     wrap;
  logic                     accept;
  logic [R-1:0]             dither [N_CH];

  assign wrap           = en && (&ctr_reg);
  assign frame          = wrap;
  assign stream.s_ready = !full_reg || wrap;
  assign accept         = stream.s_valid && stream.s_ready;

  // An acceptance in the wrap cycle refills the buffer for the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_reg  <= '0;
      full_reg <= 1'b0;
      pend_reg <= '0;
    end else begin
      ctr_reg <= en ? ctr_reg + 1'b1 : '0;
      if (accept) begin
        full_reg <= 1'b1;
        pend_reg <= stream.s_data;
      end else if (wrap) begin
        full_reg <= 1'b0;
      end
    end
  end

`ifdef APU_SDM_MC_DITHER_EN
  logic [15:0]   lfsr_reg;
  logic [R+15:0] lfsr_ext;
  logic [R-1:0]  dither_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg <= LFSR_SEED;
    end else if (wrap) begin
      lfsr_reg <= (lfsr_reg >> 1) ^ (lfsr_reg[0] ? LFSR_POLY : 16'h0000);
    end
  end

  assign lfsr_ext    = (R+16)'(lfsr_reg);
  assign dither_base = lfsr_ext[R-1:0] >> 1;
`endif

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_dither
`ifdef APU_SDM_MC_DITHER_EN
    localparam int K = gi % R;
    // Rotating per channel decorrelates the dither between channels.
    assign dither[gi] = R'((dither_base << K) | (dither_base >> (R - K)));
`else
    assign dither[gi] = '0;
`endif
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    apu_sdm_mc_ch #(
      .W_SAMPLE  (W_SAMPLE),
      .W_PWM     (W_PWM),
      .SIGNED_IN (SIGNED_IN)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .wrap       (wrap),
      .use_buf    (full_reg),
      .buf_sample (pend_reg[gi*W_SAMPLE +: W_SAMPLE]),
      .dither     (dither[gi]),
      .pwm_ctr    (ctr_reg),
      .q          (q[gi])
    );
  end

endmodule

// File: tb/tb_apu_sdm_mc.sv
// Directed self-checking bench for apu_sdm_mc: unsigned and signed instances side by side.
module tb_apu_sdm_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       frame;
  logic       frame_s;
  logic [1:0] q;
  logic [1:0] q_s;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  apu_sdm_mc_if #(.N_CH(2), .W_SAMPLE(16)) bus ();
  apu_sdm_mc_if #(.N_CH(2), .W_SAMPLE(16)) bus_s ();

  apu_sdm_mc #(.N_CH(2), .W_SAMPLE(16), .W_PWM(4), .SIGNED_IN(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .stream(bus), .frame(frame), .q(q)
  );

  apu_sdm_mc #(.N_CH(2), .W_SAMPLE(16), .W_PWM(4), .SIGNED_IN(1)) u_dut_s (
    .clk(clk), .rst(rst), .en(en), .stream(bus_s), .frame(frame_s), .q(q_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle of the next frame (pwm_ctr = 0).
  task automatic sync_frame(input string tag);
    int n = 0;
    while (!frame && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_frame_seen"}, 32'(frame), 32'd1);
    tick();
  endtask

  // Records q over one 16-cycle frame; bit i is q while pwm_ctr = i+1.
  task automatic run_frame(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                           input bit chk_s, input logic [15:0] es0, input logic [15:0] es1);
    logic [15:0] p0, p1, r0, r1;
    for (int i = 0; i < 16; i++) begin
      tick();
      p0[i] = q[0];
      p1[i] = q[1];
      r0[i] = q_s[0];
      r1[i] = q_s[1];
    end
    check({tag, "_q0"}, 32'(p0), 32'(e0));
    check({tag, "_q1"}, 32'(p1), 32'(e1));
    if (chk_s) begin
      check({tag, "_sq0"}, 32'(r0), 32'(es0));
      check({tag, "_sq1"}, 32'(r1), 32'(es1));
    end
  endtask

  task automatic send(input string tag, input logic [31:0] d);
    int n = 0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 32'(bus.s_ready), 32'd1);
    tick();
    bus.s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1;
    en  = 1'b0;
    bus.s_data    = '0;
    bus.s_valid   = 1'b0;
    bus_s.s_data  = '0;
    bus_s.s_valid = 1'b0;
    tick();
    tick();
    check("rst_ready",   32'(bus.s_ready),   32'd1);
    check("rst_frame",   32'(frame),         32'd0);
    check("rst_q",       32'(q),             32'd0);
    check("rst_s_ready", 32'(bus_s.s_ready), 32'd1);
    check("rst_s_q",     32'(q_s),           32'd0);

    // Midscale / quarter scale, and signed 0x0000 / 0x8000 on the second instance.
    rst = 1'b0;
    en  = 1'b1;
    bus.s_data    = {16'h4000, 16'h8000};
    bus.s_valid   = 1'b1;
    bus_s.s_data  = {16'h8000, 16'h0000};
    bus_s.s_valid = 1'b1;
    check("mid_ready",   32'(bus.s_ready),   32'd1);
    check("mid_s_ready", 32'(bus_s.s_ready), 32'd1);
    tick();
    bus.s_valid   = 1'b0;
    bus_s.s_valid = 1'b0;
    sync_frame("mid");
    run_frame("mid_a", 16'h00FF, 16'h000F, 1'b1, 16'h00FF, 16'h0000);
    run_frame("mid_b", 16'h00FF, 16'h000F, 1'b1, 16'h00FF, 16'h0000);

    // Low level alternates 0/1; full scale gives 15 then 16 with the residual carried.
    send("low", {16'hFFFF, 16'h0800});
    sync_frame("low");
    run_frame("low_0", 16'h0000, 16'h7FFF, 1'b0, 16'h0, 16'h0);
    run_frame("low_1", 16'h0001, 16'hFFFF, 1'b0, 16'h0, 16'h0);
    run_frame("low_2", 16'h0000, 16'hFFFF, 1'b0, 16'h0, 16'h0);
    run_frame("low_3", 16'h0001, 16'hFFFF, 1'b0, 16'h0, 16'h0);

    // Back-pressure: second frame waits for the wrap cycle.
    for (int i = 0; i < 4; i++) tick();
    bus.s_data  = {16'h8000, 16'h8000};
    bus.s_valid = 1'b1;
    check("bp_ready_a", 32'(bus.s_ready), 32'd1);
    tick();
    bus.s_data = {16'h2000, 16'h4000};
    check("bp_ready_b_low", 32'(bus.s_ready), 32'd0);
    n = 0;
    while (!bus.s_ready && n < 40) begin
      tick();
      n++;
    end
    check("bp_wait",  32'(n),     32'd10);
    check("bp_frame", 32'(frame), 32'd1);
    tick();
    bus.s_valid = 1'b0;
    check("bp_full_after_wrap", 32'(bus.s_ready), 32'd0);
    run_frame("bp_a", 16'h00FF, 16'h00FF, 1'b0, 16'h0, 16'h0);
    check("bp_drained", 32'(bus.s_ready), 32'd1);
    run_frame("bp_b",   16'h000F, 16'h0003, 1'b0, 16'h0, 16'h0);
    run_frame("bp_rep", 16'h000F, 16'h0003, 1'b0, 16'h0, 16'h0);

    // Enable dropped mid-frame; a frame loaded while disabled applies at the first wrap.
    for (int i = 0; i < 3; i++) tick();
    check("en_pre_q", 32'(q), 32'd1);
    en = 1'b0;
    tick();
    check("en_off_q",     32'(q),     32'd0);
    check("en_off_frame", 32'(frame), 32'd0);
    bus.s_data  = {16'h1000, 16'hC000};
    bus.s_valid = 1'b1;
    check("en_off_ready", 32'(bus.s_ready), 32'd1);
    tick();
    bus.s_valid = 1'b0;
    check("en_off_full", 32'(bus.s_ready), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("en_off_hold_q", 32'(q), 32'd0);
    en = 1'b1;
    run_frame("en_first",  16'h0000, 16'h0000, 1'b0, 16'h0, 16'h0);
    run_frame("en_resume", 16'h0FFF, 16'h0001, 1'b0, 16'h0, 16'h0);

    // Asynchronous reset mid-frame with a frame pending.
    bus.s_data  = {16'h3000, 16'h3000};
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    tick();
    tick();
    check("rst_pre_q",     32'(q),             32'd1);
    check("rst_pre_ready", 32'(bus.s_ready),   32'd0);
    rst = 1'b1;
    #1;
    check("rst_async_q",     32'(q),           32'd0);
    check("rst_async_ready", 32'(bus.s_ready), 32'd1);
    check("rst_async_frame", 32'(frame),       32'd0);
    tick();
    rst = 1'b0;
    sync_frame("post_rst");
    run_frame("post_rst", 16'h0000, 16'h0000, 1'b0, 16'h0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
